// File: rtl/sift_pkg.sv
// Shared definitions for the SIFT stage sequencer: FSM state encoding,
// status-report word order and fixed widths.
package sift_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_GAP    = 3'd2,
      ST_REPORT = 3'd3,
      ST_ERR    = 3'd4
   } sift_state_e;

   // Order in which the status words leave on out_data during REPORT.
   typedef enum logic [1:0] {
      WORD_KP1    = 2'd0,
      WORD_KP2    = 2'd1,
      WORD_CYCLES = 2'd2
   } status_word_e;

   localparam int REPORT_WORDS = 3;
   localparam int STATUS_W     = 16;
   localparam int IDX_W        = 3;

endpackage

// File: rtl/sift_stage_mux.sv
// Combinational slice select that hands the shared image, blur-memory and
// line-buffer controls to the currently active stage.
module sift_stage_mux
   import sift_pkg::*;
#(
   parameter int NUM_STAGES = 2,
   parameter int NUM_BLUR   = 4,
   parameter int ADDR_W     = 9
) (
   input  logic                                  enable,
   input  logic [IDX_W-1:0]                      idx,
   input  logic [NUM_STAGES*ADDR_W-1:0]          stage_img_addr,
   input  logic [NUM_STAGES*NUM_BLUR*ADDR_W-1:0] stage_blur_addr,
   input  logic [NUM_STAGES-1:0]                 stage_buffer_we,
   output logic [ADDR_W-1:0]                     img_addr,
   output logic [NUM_BLUR*ADDR_W-1:0]            blur_addr,
   output logic                                  buffer_we
);

   localparam int BLUR_W = NUM_BLUR * ADDR_W;

   // Outside RUN/GAP every shared control is parked at zero.
   always_comb begin
      img_addr  = '0;
      blur_addr = '0;
      buffer_we = 1'b0;
      for (int s = 0; s < NUM_STAGES; s++) begin
         if (enable && (idx == IDX_W'(s))) begin
            img_addr  = stage_img_addr[s*ADDR_W +: ADDR_W];
            blur_addr = stage_blur_addr[s*BLUR_W +: BLUR_W];
            buffer_we = stage_buffer_we[s];
         end
      end
   end

endmodule

// File: rtl/sift_stage_sequencer.sv
// Top-level SIFT sequencer: runs the stage engines strictly in order, owns the
// shared memory muxes, guards each stage with a watchdog and reports results.
module sift_stage_sequencer
   import sift_pkg::*;
#(
   parameter int NUM_STAGES = 2,
   parameter int NUM_BLUR   = 4,
   parameter int ADDR_W     = 9,
   parameter int KP_CNT_W   = 11,
   parameter int WDOG_W     = 20
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  in_valid,
   input  logic                                  abort,
   input  logic [NUM_STAGES-1:0]                 stage_done,
   input  logic [NUM_STAGES*ADDR_W-1:0]          stage_img_addr,
   input  logic [NUM_STAGES*NUM_BLUR*ADDR_W-1:0] stage_blur_addr,
   input  logic [NUM_STAGES-1:0]                 stage_buffer_we,
   input  logic [KP_CNT_W-1:0]                   kp1_count,
   input  logic [KP_CNT_W-1:0]                   kp2_count,
   output logic [NUM_STAGES-1:0]                 stage_start,
   output logic [ADDR_W-1:0]                     img_addr,
   output logic [NUM_BLUR*ADDR_W-1:0]            blur_addr,
   output logic                                  buffer_we,
   output logic [2:0]                            buffer_mode,
   output logic                                  busy,
   output logic                                  error,
   output logic [2:0]                            err_stage,
   output logic                                  out_valid,
   output logic [STATUS_W-1:0]                   out_data
);

   localparam logic [WDOG_W-1:0] WDOG_MAX  = {WDOG_W{1'b1}};
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_MAX - WDOG_W'(1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_STAGES - 1);
   localparam logic [1:0]        LAST_WORD = 2'(REPORT_WORDS - 1);

   sift_state_e               state, state_next;
   logic [IDX_W-1:0]          idx, idx_next;
   logic [WDOG_W-1:0]         wdog, wdog_next, wdog_inc;
   logic [STATUS_W-1:0]       cyc_cnt, cyc_next, cyc_inc;
   logic [1:0]                rpt_cnt, rpt_next;
   logic [KP_CNT_W-1:0]       kp1_q, kp2_q;
   logic                      kp_capture;
   logic                      error_q, error_next;
   logic [2:0]                err_stage_q, err_stage_next;
   logic [NUM_STAGES-1:0]     start_q, start_next;
   logic                      active_done;
   logic                      mux_en;

   always_comb begin
      active_done = 1'b0;
      for (int s = 0; s < NUM_STAGES; s++) begin
         if (idx == IDX_W'(s)) active_done = stage_done[s];
      end
   end

   assign wdog_inc = (wdog == WDOG_MAX) ? wdog : wdog + 1'b1;
   assign cyc_inc  = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + 1'b1;

   // Abort overrides every transition; done is tested before watchdog expiry.
   always_comb begin
      state_next     = state;
      idx_next       = idx;
      wdog_next      = wdog;
      cyc_next       = cyc_cnt;
      rpt_next       = rpt_cnt;
      error_next     = error_q;
      err_stage_next = err_stage_q;
      kp_capture     = 1'b0;
      if (abort) begin
         state_next = ST_IDLE;
         idx_next   = '0;
         wdog_next  = '0;
         rpt_next   = '0;
         if (state == ST_ERR) begin
            error_next     = 1'b0;
            err_stage_next = '0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  state_next = ST_RUN;
                  idx_next   = '0;
                  wdog_next  = '0;
                  cyc_next   = '0;
               end
            end
            ST_RUN: begin
               cyc_next  = cyc_inc;
               wdog_next = wdog_inc;
               if (active_done) begin
                  if (idx == LAST_IDX) begin
                     state_next = ST_REPORT;
                     rpt_next   = '0;
                     kp_capture = 1'b1;
                  end else begin
                     state_next = ST_GAP;
                     idx_next   = idx + 1'b1;
                  end
               end else if (wdog == WDOG_LAST) begin
                  state_next     = ST_ERR;
                  error_next     = 1'b1;
                  err_stage_next = idx;
               end
            end
            ST_GAP: begin
               cyc_next   = cyc_inc;
               wdog_next  = '0;
               state_next = ST_RUN;
            end
            ST_REPORT: begin
               if (rpt_cnt == LAST_WORD) begin
                  state_next = ST_IDLE;
                  rpt_next   = '0;
                  idx_next   = '0;
               end else begin
                  rpt_next = rpt_cnt + 1'b1;
               end
            end
            ST_ERR: begin
               if (in_valid) begin
                  state_next     = ST_RUN;
                  idx_next       = '0;
                  wdog_next      = '0;
                  cyc_next       = '0;
                  error_next     = 1'b0;
                  err_stage_next = '0;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      start_next = '0;
      for (int s = 0; s < NUM_STAGES; s++) begin
         start_next[s] = (state_next == ST_RUN) && (idx_next == IDX_W'(s));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         idx         <= '0;
         wdog        <= '0;
         cyc_cnt     <= '0;
         rpt_cnt     <= '0;
         kp1_q       <= '0;
         kp2_q       <= '0;
         error_q     <= 1'b0;
         err_stage_q <= '0;
         start_q     <= '0;
      end else begin
         state       <= state_next;
         idx         <= idx_next;
         wdog        <= wdog_next;
         cyc_cnt     <= cyc_next;
         rpt_cnt     <= rpt_next;
         error_q     <= error_next;
         err_stage_q <= err_stage_next;
         start_q     <= start_next;
         if (kp_capture) begin
            kp1_q <= kp1_count;
            kp2_q <= kp2_count;
         end
      end
   end

   assign mux_en      = (state == ST_RUN) || (state == ST_GAP);
   assign stage_start = start_q;
   assign buffer_mode = mux_en ? (idx + 3'd1) : 3'd0;
   assign busy        = state inside {ST_RUN, ST_GAP, ST_REPORT};
   assign error       = error_q;
   assign err_stage   = err_stage_q;

   always_comb begin
      out_valid = 1'b0;
      out_data  = '0;
      if (state == ST_REPORT) begin
         out_valid = 1'b1;
         case (rpt_cnt)
            WORD_KP1:    out_data = STATUS_W'(kp1_q);
            WORD_KP2:    out_data = STATUS_W'(kp2_q);
            WORD_CYCLES: out_data = cyc_cnt;
            default:     out_data = '0;
         endcase
      end
   end

   sift_stage_mux #(
      .NUM_STAGES(NUM_STAGES),
      .NUM_BLUR  (NUM_BLUR),
      .ADDR_W    (ADDR_W)
   ) u_mux (
      .enable         (mux_en),
      .idx            (idx),
      .stage_img_addr (stage_img_addr),
      .stage_blur_addr(stage_blur_addr),
      .stage_buffer_we(stage_buffer_we),
      .img_addr       (img_addr),
      .blur_addr      (blur_addr),
      .buffer_we      (buffer_we)
   );

endmodule

// File: tb/tb_sift_stage_sequencer.sv
// Self-checking bench for sift_stage_sequencer: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_sift_stage_sequencer;

   localparam int NUM_STAGES = 2;
   localparam int NUM_BLUR   = 4;
   localparam int ADDR_W     = 9;
   localparam int KP_CNT_W   = 11;
   localparam int WDOG_W     = 8;
   localparam int BLUR_W     = NUM_BLUR * ADDR_W;
   localparam int WDOG_LIMIT = (1 << WDOG_W) - 1;

   logic                             clk = 1'b0;
   logic                             rst_n;
   logic                             in_valid;
   logic                             abort;
   logic [NUM_STAGES-1:0]            stage_done;
   logic [NUM_STAGES*ADDR_W-1:0]     stage_img_addr;
   logic [NUM_STAGES*BLUR_W-1:0]     stage_blur_addr;
   logic [NUM_STAGES-1:0]            stage_buffer_we;
   logic [KP_CNT_W-1:0]              kp1_count;
   logic [KP_CNT_W-1:0]              kp2_count;
   logic [NUM_STAGES-1:0]            stage_start;
   logic [ADDR_W-1:0]                img_addr;
   logic [BLUR_W-1:0]                blur_addr;
   logic                             buffer_we;
   logic [2:0]                       buffer_mode;
   logic                             busy;
   logic                             error;
   logic [2:0]                       err_stage;
   logic                             out_valid;
   logic [15:0]                      out_data;

   always #5 clk = ~clk;

   sift_stage_sequencer #(
      .NUM_STAGES(NUM_STAGES),
      .NUM_BLUR  (NUM_BLUR),
      .ADDR_W    (ADDR_W),
      .KP_CNT_W  (KP_CNT_W),
      .WDOG_W    (WDOG_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .abort          (abort),
      .stage_done     (stage_done),
      .stage_img_addr (stage_img_addr),
      .stage_blur_addr(stage_blur_addr),
      .stage_buffer_we(stage_buffer_we),
      .kp1_count      (kp1_count),
      .kp2_count      (kp2_count),
      .stage_start    (stage_start),
      .img_addr       (img_addr),
      .blur_addr      (blur_addr),
      .buffer_we      (buffer_we),
      .buffer_mode    (buffer_mode),
      .busy           (busy),
      .error          (error),
      .err_stage      (err_stage),
      .out_valid      (out_valid),
      .out_data       (out_data)
   );

   int n_checks = 0;
   int n_pass   = 0;
   bit check_en = 1'b0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: what the sequencer is doing, in terms of runs and stages.
   typedef enum {M_IDLE, M_STAGE, M_HANDOFF, M_REPORT, M_FAULT} mode_t;
   mode_t m_mode = M_IDLE;
   int    m_stage = 0, m_age = 0, m_total = 0, m_word = 0;
   int    m_kp1 = 0, m_kp2 = 0, m_err_stage = 0;
   bit    m_err = 1'b0;

   task automatic modelStep();
      if (!rst_n) begin
         m_mode = M_IDLE; m_stage = 0; m_age = 0; m_total = 0; m_word = 0;
         m_kp1 = 0; m_kp2 = 0; m_err = 1'b0; m_err_stage = 0;
      end else if (abort) begin
         if (m_mode == M_FAULT) begin m_err = 1'b0; m_err_stage = 0; end
         m_mode = M_IDLE;
      end else begin
         case (m_mode)
            M_IDLE: if (in_valid) begin m_mode = M_STAGE; m_stage = 0; m_age = 0; m_total = 0; end
            M_STAGE: begin
               m_age++;
               if (m_total < 65535) m_total++;
               if (stage_done[m_stage]) begin
                  if (m_stage == NUM_STAGES - 1) begin
                     m_mode = M_REPORT; m_word = 0;
                     m_kp1 = int'(kp1_count); m_kp2 = int'(kp2_count);
                  end else begin
                     m_mode = M_HANDOFF; m_stage++;
                  end
               end else if (m_age == WDOG_LIMIT) begin
                  m_mode = M_FAULT; m_err = 1'b1; m_err_stage = m_stage;
               end
            end
            M_HANDOFF: begin
               if (m_total < 65535) m_total++;
               m_mode = M_STAGE; m_age = 0;
            end
            M_REPORT: begin
               m_word++;
               if (m_word == 3) m_mode = M_IDLE;
            end
            M_FAULT: if (in_valid) begin
               m_mode = M_STAGE; m_stage = 0; m_age = 0; m_total = 0; m_err = 1'b0; m_err_stage = 0;
            end
            default: m_mode = M_IDLE;
         endcase
      end
   endtask

   task automatic compareAll();
      logic [NUM_STAGES-1:0] e_start;
      logic [ADDR_W-1:0]     e_img;
      logic [BLUR_W-1:0]     e_blur;
      logic                  e_we;
      int                    e_mode, e_data;
      bit                    live;
      live    = (m_mode == M_STAGE) || (m_mode == M_HANDOFF);
      e_start = '0;
      if (m_mode == M_STAGE) e_start = NUM_STAGES'(1 << m_stage);
      e_img = '0; e_blur = '0; e_we = 1'b0; e_mode = 0;
      if (live) begin
         e_img  = ADDR_W'(stage_img_addr >> (m_stage * ADDR_W));
         e_blur = BLUR_W'(stage_blur_addr >> (m_stage * BLUR_W));
         e_we   = stage_buffer_we[m_stage];
         e_mode = m_stage + 1;
      end
      e_data = 0;
      if (m_mode == M_REPORT) e_data = (m_word == 0) ? m_kp1 : (m_word == 1) ? m_kp2 : m_total;
      checkOutput("stage_start", stage_start, e_start);
      checkOutput("img_addr", img_addr, e_img);
      checkOutput("blur_addr", blur_addr, e_blur);
      checkOutput("buffer_we", buffer_we, e_we);
      checkOutput("buffer_mode", buffer_mode, e_mode);
      checkOutput("busy", busy, live || (m_mode == M_REPORT));
      checkOutput("error", error, m_err);
      if (m_err) checkOutput("err_stage", err_stage, m_err_stage);
      checkOutput("out_valid", out_valid, m_mode == M_REPORT);
      checkOutput("out_data", out_data, e_data);
   endtask

   initial forever begin
      @(posedge clk);
      modelStep();
   end

   initial forever begin
      @(negedge clk);
      if (check_en) compareAll();
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input bit iv, input bit ab, input logic [NUM_STAGES-1:0] dn, input int cycles);
      in_valid   = iv;
      abort      = ab;
      stage_done = dn;
      repeat (cycles) tick();
   endtask

   task automatic randomizeBuses();
      for (int k = 0; k < NUM_STAGES * NUM_BLUR; k++)
         stage_blur_addr[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
      for (int k = 0; k < NUM_STAGES; k++)
         stage_img_addr[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
      stage_buffer_we = NUM_STAGES'($urandom);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL timeout: time limit reached before the end of the run");
      $fatal(1, "[TB] time limit reached");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; stage_done = '0;
      kp1_count = '0; kp2_count = '0;
      randomizeBuses();
      stage_img_addr = {9'h033, 9'h1A5};
      repeat (3) tick();
      check_en = 1'b1;
      @(negedge clk);
      checkOutput("reset stage_start", stage_start, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset out_data", out_data, 0);
      checkOutput("reset error", error, 0);
      rst_n = 1'b1;

      // Normal run: 100 cycles in stage 0, gap, 51 cycles in stage 1.
      applyStimulus(1, 0, '0, 1);
      @(negedge clk);
      checkOutput("run0 stage_start", stage_start, 2'b01);
      checkOutput("run0 img_addr", img_addr, 9'h1A5);
      checkOutput("run0 buffer_mode", buffer_mode, 1);
      applyStimulus(0, 0, '0, 49);
      applyStimulus(0, 0, 2'b10, 1);
      applyStimulus(0, 0, '0, 49);
      applyStimulus(0, 0, 2'b01, 1);
      @(negedge clk);
      checkOutput("gap stage_start", stage_start, 2'b00);
      checkOutput("gap img_addr", img_addr, 9'h033);
      checkOutput("gap buffer_mode", buffer_mode, 2);
      applyStimulus(0, 0, '0, 1);
      @(negedge clk);
      checkOutput("run1 stage_start", stage_start, 2'b10);
      checkOutput("run1 img_addr", img_addr, 9'h033);
      applyStimulus(0, 0, '0, 50);
      kp1_count = 11'd37; kp2_count = 11'd1999;
      applyStimulus(0, 0, 2'b10, 1);
      @(negedge clk);
      checkOutput("report word0", {out_valid, out_data}, {1'b1, 16'h0025});
      kp1_count = 11'd5; kp2_count = 11'd6;
      applyStimulus(1, 0, '0, 1);
      @(negedge clk);
      checkOutput("report word1", {out_valid, out_data}, {1'b1, 16'h07CF});
      applyStimulus(0, 0, '0, 1);
      @(negedge clk);
      checkOutput("report word2", {out_valid, out_data}, {1'b1, 16'h0098});
      applyStimulus(0, 0, '0, 1);
      @(negedge clk);
      checkOutput("post-report busy", busy, 0);
      checkOutput("post-report out_valid", out_valid, 0);
      checkOutput("post-report img_addr", img_addr, 0);

      // Watchdog on stage 1, then restart from the error state.
      applyStimulus(1, 0, '0, 1);
      applyStimulus(0, 0, '0, 9);
      applyStimulus(0, 0, 2'b01, 1);
      applyStimulus(0, 0, '0, 1);
      applyStimulus(0, 0, '0, WDOG_LIMIT - 1);
      @(negedge clk);
      checkOutput("wdog last-run error", error, 0);
      applyStimulus(0, 0, '0, 1);
      @(negedge clk);
      checkOutput("wdog error", error, 1);
      checkOutput("wdog err_stage", err_stage, 1);
      checkOutput("wdog stage_start", stage_start, 0);
      applyStimulus(1, 0, '0, 1);
      @(negedge clk);
      checkOutput("restart error", error, 0);
      checkOutput("restart stage_start", stage_start, 2'b01);

      // Abort with in_valid held in the same cycles.
      applyStimulus(0, 0, '0, 4);
      applyStimulus(1, 1, '0, 1);
      @(negedge clk);
      checkOutput("abort outputs", {stage_start, img_addr, buffer_mode, busy, out_valid}, 0);
      applyStimulus(1, 1, '0, 1);
      @(negedge clk);
      checkOutput("abort held busy", busy, 0);
      applyStimulus(0, 0, '0, 2);

      // Done and watchdog expiry in the same cycle: done wins.
      applyStimulus(1, 0, '0, 1);
      applyStimulus(0, 0, '0, WDOG_LIMIT - 1);
      applyStimulus(0, 0, 2'b01, 1);
      @(negedge clk);
      checkOutput("collision buffer_mode", buffer_mode, 2);
      checkOutput("collision error", error, 0);
      applyStimulus(0, 0, '0, 3);
      applyStimulus(0, 0, 2'b10, 1);
      @(negedge clk);
      checkOutput("abort-report out_valid before", out_valid, 1);
      applyStimulus(0, 1, '0, 1);
      @(negedge clk);
      checkOutput("abort-report out_valid after", out_valid, 0);
      applyStimulus(0, 0, '0, 2);

      // Stage 0 timeout cleared by abort.
      applyStimulus(1, 0, '0, 1);
      applyStimulus(0, 0, '0, WDOG_LIMIT);
      @(negedge clk);
      checkOutput("wdog0 error", error, 1);
      checkOutput("wdog0 err_stage", err_stage, 0);
      applyStimulus(0, 1, '0, 1);
      @(negedge clk);
      checkOutput("abort clears error", error, 0);
      applyStimulus(0, 0, '0, 1);

      // Randomized traffic, checked every cycle by the model.
      for (int c = 0; c < 6000; c++) begin
         rst_n    = ($urandom_range(0, 1999) != 0);
         in_valid = ($urandom_range(0, 7) == 0);
         abort    = ($urandom_range(0, 399) == 0);
         for (int s = 0; s < NUM_STAGES; s++) stage_done[s] = ($urandom_range(0, 149) == 0);
         kp1_count = KP_CNT_W'($urandom);
         kp2_count = KP_CNT_W'($urandom);
         randomizeBuses();
         tick();
      end

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
